// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
//
// Purpose:
//   Shared definitions for the fetch/decode front end. It holds the MIPS
//   opcode and SPECIAL-funct constants used by predecode, the machine word
//   type, and the fetch buffer entry record.
//
// Contents:
//   word_t          32-bit machine word (instructions and PCs)
//   OP_*            primary opcode field values (instr[31:26])
//   F_*             funct field values for OP_RT (instr[5:0])
//   fetch_entry_t   one fetch buffer entry: instr, pc, adel, in_delay_slot
// -----------------------------------------------------------------------------
package decode_pkg;

    typedef logic [31:0] word_t;

    // Primary opcodes that change control flow, plus the SPECIAL group.
    localparam logic [5:0] OP_RT     = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    // SPECIAL-group register jumps.
    localparam logic [5:0] F_JR      = 6'b001000;
    localparam logic [5:0] F_JALR    = 6'b001001;

    typedef struct packed {
        word_t instr;
        word_t pc;
        logic  adel;
        logic  in_delay_slot;
    } fetch_entry_t;

endpackage

// File: rtl/fb_predecode.sv
// -----------------------------------------------------------------------------
// fb_predecode
//
// Purpose:
//   Combinational predecode run on each instruction entering the fetch
//   buffer. It flags any instruction whose successor sits in a delay slot:
//   BEQ, BNE, BLEZ, BGTZ, REGIMM (any rt), J, JAL, and the SPECIAL-group
//   JR / JALR. A fetch with an address error never counts as a branch,
//   because its instruction word is not meaningful.
//
// Ports:
//   instr      in   32  fetched instruction word
//   adel       in   1   fetch address-error flag
//   is_branch  out  1   instruction is a branch or jump
// -----------------------------------------------------------------------------
module fb_predecode
    import decode_pkg::*;
(
    input  word_t instr,
    input  logic  adel,
    output logic  is_branch
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    // rs/rt/rd/shamt/immediate bits play no part in the decision.
    assign unused_fields = ^instr[25:6];

    always_comb begin
        is_branch = 1'b0;
        case (opcode)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
            OP_REGIMM, OP_J, OP_JAL: is_branch = 1'b1;
            OP_RT:                   is_branch = (funct == F_JR) || (funct == F_JALR);
            default:                 is_branch = 1'b0;
        endcase
        if (adel) begin
            is_branch = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//
// Purpose:
//   Instruction queue between fetch and decode. It is a circular buffer of
//   DEPTH entries (power of two, 4..16). Each entry carries the instruction,
//   its PC, the fetch address-error flag and a delay-slot flag. The
//   delay-slot flag records whether the previously pushed instruction was a
//   branch or jump. The bit is computed at push time from the prev_branch
//   register, which is loaded with the predecode result on every push.
//
//   A flush drops all entries and any push or pop in the same cycle, and
//   clears prev_branch. The reset is synchronous and active-low, and it
//   takes priority over push, pop and flush. Storage itself is never reset.
//   While the queue is empty, out_* read as zero, so out_pcplus4 reads 4.
//
// Configuration:
//   FETCH_BUFFER_BYPASS_EN  When defined, an instruction offered while the
//                           buffer is empty (and not flushing) appears on
//                           out_* in the same cycle. If decode takes it at
//                           once, it is not stored. When undefined, out_*
//                           come only from storage, so every output path is
//                           registered.
//
// Parameters:
//   DEPTH               number of queue entries (power of two, 4..16)
//
// Ports:
//   clk                 in   1   rising-edge clock
//   resetn              in   1   synchronous active-low reset
//   flush               in   1   discard all entries and any same-cycle push
//   in_valid            in   1   fetch offers an instruction
//   in_ready            out  1   buffer can accept (== !full)
//   in_instr            in   32  fetched instruction word
//   in_pc               in   32  instruction PC
//   in_adel             in   1   fetch address-error flag
//   out_valid           out  1   head entry available to decode
//   out_ready           in   1   decode consumes the head
//   out_instr           out  32  head instruction
//   out_pc              out  32  head PC
//   out_pcplus4         out  32  head PC + 4 (mod 2^32)
//   out_adel            out  1   head address-error flag
//   out_in_delay_slot   out  1   head follows a branch or jump
//   count               out  $clog2(DEPTH)+1  occupied entries
// -----------------------------------------------------------------------------
module fetch_buffer
    import decode_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  word_t                  in_instr,
    input  word_t                  in_pc,
    input  logic                   in_adel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output word_t                  out_instr,
    output word_t                  out_pc,
    output word_t                  out_pcplus4,
    output logic                   out_adel,
    output logic                   out_in_delay_slot,
    output logic [$clog2(DEPTH):0] count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             prev_branch_q, prev_branch_d;

    logic             is_branch;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             bypass;
    logic             store;
    logic             deq;
    fetch_entry_t     in_entry;
    fetch_entry_t     head;

    fb_predecode u_predecode (
        .instr     (in_instr),
        .adel      (in_adel),
        .is_branch (is_branch)
    );

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready && !flush;

    // The delay-slot bit is fixed at push time from the previous push.
    assign in_entry = '{instr:         in_instr,
                        pc:            in_pc,
                        adel:          in_adel,
                        in_delay_slot: prev_branch_q};

`ifdef FETCH_BUFFER_BYPASS_EN
    assign bypass = empty && in_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = !empty || bypass;
    assign pop       = out_valid && out_ready && !flush;

    // A bypassed instruction taken at once skips storage entirely. A pop
    // that comes from the bypass path leaves the read side untouched.
    assign store = push && !(bypass && out_ready);
    assign deq   = pop && !bypass;

    // An empty queue shows all-zero fields, so nothing stale leaks out.
    always_comb begin
        head = '0;
        if (bypass) begin
            head = in_entry;
        end else if (!empty) begin
            head = mem_q[rd_ptr_q];
        end
    end

    assign out_instr         = head.instr;
    assign out_pc            = head.pc;
    assign out_pcplus4       = head.pc + 32'd4;
    assign out_adel          = head.adel;
    assign out_in_delay_slot = head.in_delay_slot;
    assign count             = count_q;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        prev_branch_d = prev_branch_q;

        if (flush) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            prev_branch_d = 1'b0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (store) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({store, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (push) begin
                prev_branch_d = is_branch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            prev_branch_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            prev_branch_q <= prev_branch_d;
        end
    end

    // Storage is not reset. Writes are held off during reset so that a
    // reset cycle leaves the contents untouched.
    always_ff @(posedge clk) begin
        if (resetn && store) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;
    import decode_pkg::*;

    localparam int DEPTH = 8;
`ifdef FETCH_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, in_ready, in_adel;
    logic        out_valid, out_ready, out_adel, out_in_delay_slot;
    logic [31:0] in_instr, in_pc, out_instr, out_pc, out_pcplus4;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        adel;
        logic        ds;
    } ref_t;

    ref_t model_q[$];
    bit   prev_br = 1'b0;

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_instr          (in_instr),
        .in_pc             (in_pc),
        .in_adel           (in_adel),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_instr         (out_instr),
        .out_pc            (out_pc),
        .out_pcplus4       (out_pcplus4),
        .out_adel          (out_adel),
        .out_in_delay_slot (out_in_delay_slot),
        .count             (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rule: opcodes 1..7 are REGIMM/J/JAL/BEQ/BNE/BLEZ/BGTZ,
    // and opcode 0 with funct 8/9 is JR/JALR. An address error voids the flag.
    function automatic bit ref_branch(input logic [31:0] ins, input bit adel);
        int op;
        int fn;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        if (adel) return 1'b0;
        if (op == 0) return (fn == 8) || (fn == 9);
        return (op >= 1) && (op <= 7);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        r[31:26] = 6'($urandom_range(0, 9));
        if (r[31:26] == 6'd0) r[5:0] = 6'($urandom_range(7, 10));
        return r;
    endfunction

    // One clock cycle: drive inputs, check the registered state against the
    // model, then advance the model by what the cycle's inputs will do.
    task automatic step(input bit rst_n, input bit fl, input bit v,
                        input logic [31:0] ins, input logic [31:0] p,
                        input bit adel, input bit rdy);
        int   sz;
        bit   exp_valid;
        ref_t e;
        @(posedge clk);
        #1;
        resetn    = rst_n;
        flush     = fl;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = p;
        in_adel   = adel;
        out_ready = rdy;
        #1;
        sz = model_q.size();
        chk("count", 32'(count), 32'(sz));
        chk("in_ready", 32'(in_ready), 32'(sz < DEPTH));
        exp_valid = (sz > 0) || (BYP && v && !fl);
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        if (!rst_n || fl) begin
            model_q.delete();
            prev_br = 1'b0;
        end else if (v && sz < DEPTH) begin
            e = '{ins, p, adel, prev_br};
            model_q.push_back(e);
            prev_br = ref_branch(ins, adel);
        end
    endtask

    task automatic idle(input bit rdy);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, rdy);
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] p, input bit adel, input bit rdy);
        step(1'b1, 1'b0, 1'b1, ins, p, adel, rdy);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    endtask

    // Scoreboard monitor: every completed handshake consumes the oldest
    // expected entry.
    always @(negedge clk) begin
        ref_t e;
        if (armed && resetn === 1'b1 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (model_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_underflow: got out_instr %0h expected no entry at %0t", out_instr, $time);
            end else begin
                e = model_q.pop_front();
                chk("out_instr", out_instr, e.instr);
                chk("out_pc", out_pc, e.pc);
                chk("out_pcplus4", out_pcplus4, e.pc + 32'd4);
                chk("out_adel", 32'(out_adel), 32'(e.adel));
                chk("out_in_delay_slot", 32'(out_in_delay_slot), 32'(e.ds));
            end
        end
    end

    initial begin
        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = 32'h0;
        in_adel   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        armed = 1'b1;

        // Reset state.
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        idle(1'b0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_pcplus4", out_pcplus4, 32'h4);
        chk("rst_out_adel", 32'(out_adel), 32'h0);

        // A single push becomes visible one cycle later.
        push(32'h24080001, 32'hBFC00000, 1'b0, 1'b0);
        idle(1'b0);
        chk("first_pcplus4", out_pcplus4, 32'hBFC00004);
        chk("first_ds", 32'(out_in_delay_slot), 32'h0);
        idle(1'b0);
        chk("held_instr", out_instr, 32'h24080001);
        drain();

        // Delay-slot flags after BEQ: 0,1,0.
        push(32'h10000003, 32'h100, 1'b0, 1'b0);
        push(32'h24080001, 32'h104, 1'b0, 1'b0);
        push(32'h24080001, 32'h108, 1'b0, 1'b0);
        idle(1'b0);
        chk("beq_ds", 32'(out_in_delay_slot), 32'h0);
        drain();

        // Fill to full, refuse a ninth, pop one, then wrap the pointers.
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) push(32'h24080000 + 32'(i), 32'h200 + 32'(4 * i), 1'b0, 1'b0);
        push(32'hDEADBEEF, 32'h300, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);
        for (int i = 0; i < 20; i++) push(rand_instr(), 32'h400 + 32'(4 * i), 1'b0, 1'b1);
        drain();

        // Flush after JR, with a push offered in the same cycle.
        push(32'h03E00008, 32'h500, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h24080002, 32'h504, 1'b0, 1'b1);
        idle(1'b0);
        push(32'h24080003, 32'h508, 1'b0, 1'b0);
        idle(1'b0);
        chk("post_flush_ds", 32'(out_in_delay_slot), 32'h0);
        drain();

        // Continuous streaming into an empty buffer.
        for (int i = 0; i < 6; i++) push(32'h24080010 + 32'(i), 32'h600 + 32'(4 * i), 1'b0, 1'b1);
        drain();

        // Address error suppresses the branch flag for the next entry.
        push(32'h10000000, 32'h700, 1'b1, 1'b0);
        push(32'h24080004, 32'h704, 1'b0, 1'b0);
        idle(1'b0);
        chk("adel_head", 32'(out_adel), 32'h1);
        drain();

        // Randomized traffic with occasional flush and mid-stream reset.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 7),
                 rand_instr(),
                 $urandom & 32'hFFFF_FFFC,
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) < 6));
        end
        drain();
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
